// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped write-back/write-allocate D-cache; cpu_* load/store+stall side, mem_* 256-bit block enable/ack side
module data_cache_ctrl #(
  parameter int LINES = 32,
  parameter int TAG_W = 22
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  localparam int IW = $clog2(LINES);
  typedef enum logic [1:0] {RESET, IDLE, WB, ALLOC} state_t;
  state_t state;
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [255:0] data_q [LINES];
  logic [26:0] fill_q;
  logic [IW-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic [2:0] w;
  logic idle, req, hit, miss, wr_hit, fill_done, unused;
  assign idx = cpu_addr_i[5 +: IW];
  assign tag = cpu_addr_i[31 -: TAG_W];
  assign w = cpu_addr_i[4:2];
  // the miss block address is latched so the refill lands correctly even if the request drops
  assign fill_idx = fill_q[IW-1:0];
  assign fill_tag = fill_q[26 -: TAG_W];
  assign unused = ^cpu_addr_i[1:0];
  assign idle = (state == RESET) || (state == IDLE);
  assign req = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit = req & valid_q[idx] & (tag_q[idx] == tag);
  assign miss = req & ~hit;
  assign wr_hit = idle & cpu_MemWrite_i & hit;
  assign fill_done = (state == ALLOC) & mem_ack_i;
  assign cpu_stall_o = miss | ~idle;
  assign cpu_data_o = cpu_MemRead_i ? data_q[idx][{w, 5'b0} +: 32] : 32'h0;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= RESET;
      mem_enable_o <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      fill_q <= '0;
    end else begin
      case (state)
        RESET, IDLE: begin
          if (wr_hit) dirty_q[idx] <= 1'b1;
          if (miss) begin
            fill_q <= cpu_addr_i[31:5];
            mem_enable_o <= 1'b1;
            if (valid_q[idx] & dirty_q[idx]) begin
              state <= WB;
              mem_write_o <= 1'b1;
              mem_addr_o <= {tag_q[idx], idx, 5'b0};
              mem_data_o <= data_q[idx];
            end else begin
              state <= ALLOC;
              mem_write_o <= 1'b0;
              mem_addr_o <= {cpu_addr_i[31:5], 5'b0};
            end
          end else state <= IDLE;
        end
        WB: if (mem_ack_i) begin
          state <= ALLOC;
          mem_write_o <= 1'b0;
          mem_addr_o <= {fill_q, 5'b0};
        end
        ALLOC: if (mem_ack_i) begin
          state <= IDLE;
          mem_enable_o <= 1'b0;
          valid_q[fill_idx] <= 1'b1;
          dirty_q[fill_idx] <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      data_q[fill_idx] <= mem_data_i;
      tag_q[fill_idx] <= fill_tag;
    end else if (wr_hit) data_q[idx][{w, 5'b0} +: 32] <= cpu_data_i;
  end
endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb_data_cache_ctrl: scoreboard bench for data_cache_ctrl with a latency-configurable backing memory
module tb_data_cache_ctrl;
  logic clk = 0, rst_n = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata, mem_addr;
  logic cpu_rd = 0, cpu_wr = 0, stall, mem_en, mem_wr, mem_ack = 0;
  logic [255:0] mem_wdata, mem_rdata = '0;
  int n_chk = 0, n_pass = 0, ack_lat = 3;
  typedef struct {logic w; logic [31:0] a;} txn_t;
  txn_t txn_q[$];
  logic [31:0] exp_q[$];
  int stall_q[$];
  logic [255:0] bmem [logic [31:0]];
  logic [31:0] ref_w [logic [31:0]];
  always #5 clk = ~clk;
  data_cache_ctrl dut (
    .clk_i(clk), .rst_i(rst_n), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_MemRead_i(cpu_rd), .cpu_MemWrite_i(cpu_wr), .cpu_data_o(cpu_rdata), .cpu_stall_o(stall),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h44) ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [255:0] get_blk(input logic [31:0] ba);
    logic [255:0] b;
    if (bmem.exists(ba)) return bmem[ba];
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = init_word(ba + 32'(i * 4));
    return b;
  endfunction
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [31:0] wa;
    logic [255:0] b;
    wa = {a[31:2], 2'b0};
    if (ref_w.exists(wa)) return ref_w[wa];
    b = get_blk({a[31:5], 5'b0});
    return b[{a[4:2], 5'b0} +: 32];
  endfunction
  task automatic push_txn(input logic w, input logic [31:0] a);
    txn_t t;
    t.w = w;
    t.a = a;
    txn_q.push_back(t);
  endtask
  // entered and left at posedge+1
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input int exp_stall);
    int n = 0;
    stall_q.push_back(exp_stall);
    if (rd && !wr) exp_q.push_back(exp_word(a));
    cpu_addr = a;
    cpu_wdata = d;
    cpu_rd = rd;
    cpu_wr = wr;
    @(negedge clk);
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("stall@%h", a), n, stall_q.pop_front());
    if (rd && !wr) check($sformatf("rdata@%h", a), cpu_rdata, exp_q.pop_front());
    if (wr) ref_w[{a[31:2], 2'b0}] = d;
    @(posedge clk);
    #1;
    cpu_rd = 0;
    cpu_wr = 0;
  endtask
  initial begin
    int cnt = 0;
    logic [31:0] a0 = 0;
    txn_t t;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 0;
      if (!mem_en) cnt = 0;
      else begin
        cnt++;
        if (cnt == 1) begin
          a0 = mem_addr;
          check("txn_expected", txn_q.size() != 0, 1);
          if (txn_q.size() != 0) begin
            t = txn_q.pop_front();
            check("txn_write", mem_wr, t.w);
            check("txn_addr", mem_addr, t.a);
          end
        end
        if (cnt == ack_lat) begin
          check("txn_stable", mem_addr, a0);
          if (mem_wr) bmem[mem_addr] = mem_wdata;
          else mem_rdata = get_blk(mem_addr);
          mem_ack = 1;
          cnt = 0;
        end
      end
    end
  end
  initial begin
    int n;
    logic [255:0] b;
    repeat (2) @(negedge clk);
    check("rst_en", mem_en, 0);
    check("rst_wr", mem_wr, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", |mem_wdata, 0);
    check("rst_stall", stall, 0);
    check("rst_rdata", cpu_rdata, 0);
    @(posedge clk);
    #1 rst_n = 1;
    // first miss: stall immediately, registered request one cycle later, then drop mid-miss
    push_txn(0, 32'h40);
    cpu_addr = 32'h40;
    cpu_rd = 1;
    @(negedge clk);
    check("miss_stall", stall, 1);
    check("miss_en_pre", mem_en, 0);
    @(negedge clk);
    check("miss_en", mem_en, 1);
    check("miss_wr", mem_wr, 0);
    check("miss_addr", mem_addr, 32'h40);
    @(posedge clk);
    #1 cpu_rd = 0;
    n = 0;
    while (mem_en && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("drop_done", n < 50, 1);
    @(posedge clk);
    #1;
    access(1, 0, 32'h40, 0, 0);
    @(negedge clk) rst_n = 0;
    ref_w.delete();
    @(negedge clk);
    check("rst_stall2", stall, 0);
    @(posedge clk);
    #1 rst_n = 1;
    push_txn(0, 32'h40);
    access(1, 0, 32'h44, 0, 4);
    access(1, 0, 32'h48, 0, 0);
    access(0, 1, 32'h44, 32'h12345678, 0);
    access(1, 0, 32'h44, 0, 0);
    push_txn(1, 32'h40);
    push_txn(0, 32'h440);
    access(1, 0, 32'h444, 0, 7);
    b = get_blk(32'h40);
    check("wb_word1", b[63:32], 32'h12345678);
    ack_lat = 2;
    push_txn(0, 32'h860);
    access(0, 1, 32'h860, 32'hCAFEF00D, 3);
    access(1, 0, 32'h860, 0, 0);
    push_txn(1, 32'h860);
    push_txn(0, 32'h060);
    access(1, 0, 32'h060, 0, 5);
    b = get_blk(32'h860);
    check("wb_860", b[31:0], 32'hCAFEF00D);
    push_txn(0, 32'h860);
    access(1, 0, 32'h860, 0, 3);
    // reset in the middle of a write-back abandons the dirty victim
    access(0, 1, 32'h444, 32'hAAAA5555, 0);
    ack_lat = 4;
    push_txn(1, 32'h440);
    cpu_addr = 32'h44;
    cpu_rd = 1;
    n = 0;
    while (!(mem_en && mem_wr) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("wb_started", n < 20, 1);
    rst_n = 0;
    #1;
    check("rst_async_en", mem_en, 0);
    check("rst_async_wr", mem_wr, 0);
    cpu_rd = 0;
    ref_w.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    push_txn(0, 32'h40);
    access(1, 0, 32'h44, 0, 5);
    push_txn(0, 32'h440);
    access(1, 0, 32'h444, 0, 5);
    ack_lat = 1;
    push_txn(0, 32'h40);
    access(1, 1, 32'h48, 32'h11112222, 2);
    access(1, 0, 32'h48, 0, 0);
    repeat (3) @(negedge clk);
    check("txn_left", txn_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_cache_ctrl.md
# data_cache_ctrl

Direct-mapped, write-back, write-allocate data cache that answers the pipeline's MEM-stage load/store requests (MemRead/MemWrite, address, store data) and replaces the single-cycle data memory. Hits complete in the same cycle. Misses hold the pipeline through `cpu_stall_o` while a four-state FSM runs block transfers against a slower 256-bit backing memory through an enable/ack handshake.

## Interface
Parameters:
- `LINES`, 32: number of cache lines; index width is log2(LINES).
- `TAG_W`, 22: tag width, taken from address bits [31:10].

Ports:
- `clk_i`  in  1  clock; every register updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `cpu_addr_i`  in  32  byte address; [4:2] selects the word, [9:5] the index, [31:10] the tag; [1:0] are ignored.
- `cpu_data_i`  in  32  store data.
- `cpu_MemRead_i`  in  1  load request.
- `cpu_MemWrite_i`  in  1  store request; takes priority if asserted together with `cpu_MemRead_i`.
- `cpu_data_o`  out  32  load data; combinational; 0 when `cpu_MemRead_i` is low.
- `cpu_stall_o`  out  1  pipeline freeze; combinational.
- `mem_enable_o`  out  1  backing-memory transaction request; registered.
- `mem_write_o`  out  1  1 = block write, 0 = block read; registered.
- `mem_addr_o`  out  32  block address with [4:0] = 0; registered.
- `mem_data_o`  out  256  write-back block; registered.
- `mem_data_i`  in  256  refill block; valid when `mem_ack_i` is high.
- `mem_ack_i`  in  1  one-cycle pulse that completes the current transaction.

## Operation
- Per-line storage: valid, dirty, tag[21:0], data[255:0]. On reset, valid and dirty are cleared for all lines; data is not reset.
- hit = request & valid[idx] & (tag[idx] == addr[31:10]).
- `cpu_stall_o` = (request & ~hit) | (state != IDLE).
- Read hit: `cpu_data_o` = data[idx][32*w +: 32], where w = addr[4:2].
- Write hit: at the clock edge, the selected word is replaced with `cpu_data_i` and dirty[idx] is set.
- FSM states: IDLE, WB, ALLOC, plus RESET as the reset-entry alias of IDLE.
  - IDLE, miss, victim clean or invalid → ALLOC. Registers `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={addr[31:5],5'b0}.
  - IDLE, miss, victim valid and dirty → WB. Registers `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={tag[idx],idx,5'b0}, `mem_data_o`=data[idx].
  - WB, `mem_ack_i`=1 → ALLOC. `mem_enable_o` stays 1, `mem_write_o`→0, `mem_addr_o`→ the new block address. The memory starts the next transaction on the cycle after the ack.
  - ALLOC, `mem_ack_i`=1 → IDLE. The line is loaded from `mem_data_i`, tag is written, valid=1, dirty=0, and `mem_enable_o`→0.
  - Any other state with no ack: hold. All `mem_*` outputs stay stable while `mem_enable_o`=1.
- The store on a write miss is performed as a write hit in the IDLE cycle after the refill (write-allocate).
- The pipeline holds its request stable while `cpu_stall_o`=1. If the request drops mid-miss, the transfer still completes, the line is installed, and the FSM returns to IDLE.
- `mem_ack_i` in IDLE is ignored.

## Timing
- Reset values: state IDLE; `mem_enable_o`, `mem_write_o`, `mem_addr_o`, `mem_data_o` all 0; `cpu_stall_o` 0 and `cpu_data_o` 0 with no request.
- Hit: 0 stall cycles. Load data is valid in the request cycle. Store data is committed at the end of that cycle.
- Clean miss: stall = 1 + A cycles, where A is the number of cycles `mem_enable_o` is high up to and including the ack cycle.
- Dirty miss: stall = 1 + A_wb + A_alloc.
- Reset asserted mid-transaction: `mem_enable_o` drops asynchronously, the FSM goes to IDLE, all lines become invalid, and the transaction is abandoned. The dirty victim is lost by definition.

## Test plan
- Reset, then load from 0x0000_0040 → `cpu_stall_o`=1 and, next cycle, `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`=0x40. All `mem_*` outputs are 0 during reset.
- Load 0x0000_0044, ack in the 3rd enable cycle with word1 of `mem_data_i` = 0xDEADBEEF → stall exactly 4 cycles, then `cpu_data_o`=0xDEADBEEF. A following load of 0x48 has stall 0.
- Store 0x12345678 to 0x44 (hit) → stall 0. Next-cycle load of 0x44 returns 0x12345678.
- Load 0x0000_0444 (index 2, tag 1) → WB with `mem_addr_o`=0x40, `mem_write_o`=1, `mem_data_o`[63:32]=0x12345678. After the ack, ALLOC with `mem_addr_o`=0x440. Final data comes from the refill.
- Store miss to 0x0000_0860 (clean victim) → refill from 0x860, then the word is written and the line is dirty. A later conflicting miss on the same index writes it back.
- `rst_i` pulled low during WB → `mem_enable_o`=0 immediately. After release, a load of 0x44 misses with `mem_write_o`=0.
